// File: rtl/pkt_dispatcher.sv
// pkt_dispatcher: queues packet base addresses in a small FIFO and hands
// each one to an idle proc instance in round-robin order. It drives the
// proc start/ready handshake, reports completions, and can quiesce every
// proc so that the shared modify buses can be driven safely.
// Optional counters are built when PKT_DISPATCHER_STATS_EN is defined.
module pkt_dispatcher #(
  parameter int NUM_PROC   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pkt_valid_i,
  input  logic [ADDR_W-1:0]          pkt_addr_i,
  output logic                       pkt_ready_o,
  output logic [NUM_PROC-1:0]        proc_start_o,
  output logic [NUM_PROC*ADDR_W-1:0] proc_pkt_addr_o,
  input  logic [NUM_PROC-1:0]        proc_ready_i,
  output logic [NUM_PROC-1:0]        done_o,
  output logic [NUM_PROC*ADDR_W-1:0] done_addr_o,
  input  logic                       cfg_req_i,
  output logic                       cfg_gnt_o,
  output logic                       busy_o
`ifdef PKT_DISPATCHER_STATS_EN
  ,
  output logic [31:0]                stat_issued_o,
  output logic [31:0]                stat_done_o,
  output logic [$clog2(FIFO_DEPTH):0] stat_max_occ_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_PROC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_REL   = 2'd3;

  localparam logic [1:0] T_RUN   = 2'd0;
  localparam logic [1:0] T_DRAIN = 2'd1;
  localparam logic [1:0] T_CFG   = 2'd2;

  logic [ADDR_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt;
  logic [1:0]          slot_st  [NUM_PROC];
  logic [1:0]          slot_nxt [NUM_PROC];
  logic [1:0]          top_st;
  logic [PW-1:0]       rr;
  logic [PW-1:0]       issue_slot;
  logic [PW-1:0]       cand;
  logic                found;
  logic                issue_en;
  logic                push;
  logic                all_idle;
  logic                any_active_nxt;
  logic [NUM_PROC-1:0] done_set;

  assign push     = pkt_valid_i && pkt_ready_o;
  assign issue_en = (top_st == T_RUN) && (count != '0) && found;

  // Find the first idle slot at or above the round-robin pointer, wrapping.
  always_comb begin
    found      = 1'b0;
    issue_slot = '0;
    cand       = '0;
    for (int k = 0; k < NUM_PROC; k++) begin
      cand = PW'((int'(rr) + k) % NUM_PROC);
      if (!found && slot_st[cand] == S_IDLE) begin
        found      = 1'b1;
        issue_slot = cand;
      end
    end
  end

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    count_nxt = count;
    if (push && !issue_en)
      count_nxt = count + CW'(1);
    else if (!push && issue_en)
      count_nxt = count - CW'(1);
  end

  // Per-slot next state; a completion is seen only in BUSY, so a stale
  // ready held over from the previous packet is ignored during ISSUE.
  always_comb begin
    done_set = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      slot_nxt[i] = slot_st[i];
      case (slot_st[i])
        S_IDLE:  if (issue_en && issue_slot == PW'(i)) slot_nxt[i] = S_ISSUE;
        S_ISSUE: slot_nxt[i] = S_BUSY;
        S_BUSY: begin
          if (proc_ready_i[i]) begin
            slot_nxt[i] = S_REL;
            done_set[i] = 1'b1;
          end
        end
        default: slot_nxt[i] = S_IDLE;
      endcase
    end
  end

  // Quiescence of the current slots and activity of the next slots.
  always_comb begin
    all_idle       = 1'b1;
    any_active_nxt = 1'b0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (slot_st[i] != S_IDLE)  all_idle       = 1'b0;
      if (slot_nxt[i] != S_IDLE) any_active_nxt = 1'b1;
    end
  end

  // FIFO pointers, occupancy and the registered not-full flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      pkt_ready_o <= 1'b1;
    end else begin
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (issue_en) rd_ptr <= rd_ptr + AW'(1);
      count       <= count_nxt;
      pkt_ready_o <= (count_nxt != CW'(FIFO_DEPTH));
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pkt_addr_i;
  end

  // Slot handshakes: start rises on issue, falls on completion; the slot
  // address is held until the next issue to that slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PROC; i++) slot_st[i] <= S_IDLE;
      proc_start_o    <= '0;
      proc_pkt_addr_o <= '0;
      done_o          <= '0;
      done_addr_o     <= '0;
      rr              <= '0;
    end else begin
      for (int i = 0; i < NUM_PROC; i++) begin
        slot_st[i] <= slot_nxt[i];
        done_o[i]  <= done_set[i];
        if (done_set[i]) begin
          proc_start_o[i]                    <= 1'b0;
          done_addr_o[i*ADDR_W +: ADDR_W]    <= proc_pkt_addr_o[i*ADDR_W +: ADDR_W];
        end
        if (issue_en && issue_slot == PW'(i)) begin
          proc_start_o[i]                    <= 1'b1;
          proc_pkt_addr_o[i*ADDR_W +: ADDR_W] <= fifo_mem[rd_ptr];
        end
      end
      if (issue_en) rr <= PW'((int'(issue_slot) + 1) % NUM_PROC);
    end
  end

  // Top-level run / drain / configure sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_st    <= T_RUN;
      cfg_gnt_o <= 1'b0;
    end else begin
      case (top_st)
        T_RUN: if (cfg_req_i) top_st <= T_DRAIN;
        T_DRAIN: begin
          if (!cfg_req_i) begin
            top_st <= T_RUN;
          end else if (all_idle) begin
            cfg_gnt_o <= 1'b1;
            top_st    <= T_CFG;
          end
        end
        T_CFG: begin
          if (!cfg_req_i) begin
            cfg_gnt_o <= 1'b0;
            top_st    <= T_RUN;
          end
        end
        default: top_st <= T_RUN;
      endcase
    end
  end

  // Busy reflects the state the FIFO and slots are entering.
  always_ff @(posedge clk) begin
    if (rst) busy_o <= 1'b0;
    else     busy_o <= (count_nxt != '0) || any_active_nxt;
  end

`ifdef PKT_DISPATCHER_STATS_EN
  // Issue/completion counters and FIFO high-water mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_o  <= '0;
      stat_done_o    <= '0;
      stat_max_occ_o <= '0;
    end else begin
      if (issue_en) stat_issued_o <= stat_issued_o + 32'd1;
      stat_done_o <= stat_done_o + 32'($countones(done_o));
      if (count_nxt > stat_max_occ_o) stat_max_occ_o <= count_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_dispatcher.sv
// Directed bench for pkt_dispatcher with NUM_PROC=4, FIFO_DEPTH=8, ADDR_W=32.
// The proc ready lines are driven directly by the stimulus sequence.
module tb_pkt_dispatcher;
  localparam int NP = 4;
  localparam int FD = 8;
  localparam int AW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             pkt_valid_i;
  logic [AW-1:0]    pkt_addr_i;
  logic             pkt_ready_o;
  logic [NP-1:0]    proc_start_o;
  logic [NP*AW-1:0] proc_pkt_addr_o;
  logic [NP-1:0]    proc_ready_i;
  logic [NP-1:0]    done_o;
  logic [NP*AW-1:0] done_addr_o;
  logic             cfg_req_i;
  logic             cfg_gnt_o;
  logic             busy_o;
`ifdef PKT_DISPATCHER_STATS_EN
  logic [31:0]      stat_issued_o;
  logic [31:0]      stat_done_o;
  logic [$clog2(FD):0] stat_max_occ_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pkt_dispatcher #(.NUM_PROC(NP), .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .pkt_valid_i(pkt_valid_i), .pkt_addr_i(pkt_addr_i), .pkt_ready_o(pkt_ready_o),
    .proc_start_o(proc_start_o), .proc_pkt_addr_o(proc_pkt_addr_o),
    .proc_ready_i(proc_ready_i), .done_o(done_o), .done_addr_o(done_addr_o),
    .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o), .busy_o(busy_o)
`ifdef PKT_DISPATCHER_STATS_EN
    , .stat_issued_o(stat_issued_o), .stat_done_o(stat_done_o),
    .stat_max_occ_o(stat_max_occ_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] paddr(input int i);
    return proc_pkt_addr_o[i*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] daddr(input int i);
    return done_addr_o[i*AW +: AW];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [AW-1:0] a);
    pkt_valid_i = 1'b1;
    pkt_addr_i  = a;
    tick();
    pkt_valid_i = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pkt_valid_i = 1'b0; pkt_addr_i = '0;
    proc_ready_i = '0; cfg_req_i = 1'b0;
    tick(); tick();
    chk("rst_ready", pkt_ready_o, 1);
    chk("rst_start", proc_start_o, 0);
    chk("rst_paddr", proc_pkt_addr_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_daddr", done_addr_o, 0);
    chk("rst_gnt", cfg_gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    rst = 1'b0;

    // single packet
    push_one(32'h100);
    chk("t1_nobypass", proc_start_o, 4'b0000);
    chk("t1_busy", busy_o, 1);
    tick();
    chk("t1_start", proc_start_o, 4'b0001);
    chk("t1_paddr0", paddr(0), 32'h100);
    tick(); tick(); tick(); tick();
    chk("t1_nodone", done_o, 4'b0000);
    proc_ready_i = 4'b0001;
    tick();
    chk("t1_done", done_o, 4'b0001);
    chk("t1_daddr0", daddr(0), 32'h100);
    chk("t1_startfall", proc_start_o, 4'b0000);
    proc_ready_i = 4'b0000;
    tick();
    chk("t1_donepulse", done_o, 4'b0000);
    chk("t1_idle", busy_o, 0);
    chk("t1_paddrhold", paddr(0), 32'h100);

    // round robin
    rst_pulse();
    push_one(32'h10);
    push_one(32'h20);
    chk("t2_s0", proc_start_o, 4'b0001);
    chk("t2_a0", paddr(0), 32'h10);
    push_one(32'h30);
    chk("t2_s1", proc_start_o, 4'b0011);
    chk("t2_a1", paddr(1), 32'h20);
    push_one(32'h40);
    chk("t2_s2", proc_start_o, 4'b0111);
    push_one(32'h50);
    chk("t2_s3", proc_start_o, 4'b1111);
    chk("t2_a3", paddr(3), 32'h40);
    tick();
    chk("t2_wait", proc_start_o, 4'b1111);
    proc_ready_i = 4'b0100;
    tick();
    chk("t2_done2", done_o, 4'b0100);
    chk("t2_daddr2", daddr(2), 32'h30);
    chk("t2_fall2", proc_start_o, 4'b1011);
    proc_ready_i = 4'b0000;
    tick();
    chk("t2_release", proc_start_o, 4'b1011);
    tick();
    chk("t2_reissue", proc_start_o, 4'b1111);
    chk("t2_a2", paddr(2), 32'h50);

    // FIFO full
    rst_pulse();
    pkt_valid_i = 1'b1;
    for (int k = 0; k < FD + NP; k++) begin
      pkt_addr_i = 32'h1000 + k;
      tick();
      if (k == FD + NP - 2) chk("t3_almost", pkt_ready_o, 1);
    end
    chk("t3_full", pkt_ready_o, 0);
    pkt_addr_i = 32'hDEAD;
    tick();
    chk("t3_stillfull", pkt_ready_o, 0);
    pkt_valid_i = 1'b0;
    proc_ready_i = 4'b0001;
    tick();
    chk("t3_done_full", pkt_ready_o, 0);
    proc_ready_i = 4'b0000;
    tick();
    chk("t3_rel_full", pkt_ready_o, 0);
    tick();
    chk("t3_head", paddr(0), 32'h1004);
    chk("t3_notfull", pkt_ready_o, 1);
    push_one(32'h2000);
    chk("t3_refull", pkt_ready_o, 0);

    // stale ready
    rst_pulse();
    for (int k = 0; k < 5; k++) push_one(32'h400 + 32'(k) * 32'h10);
    tick();
    proc_ready_i = 4'b0001;
    tick();
    chk("t4_done", done_o, 4'b0001);
    chk("t4_daddr", daddr(0), 32'h400);
    tick();
    chk("t4_rel", done_o, 4'b0000);
    tick();
    chk("t4_reissue", proc_start_o, 4'b1111);
    chk("t4_a0", paddr(0), 32'h440);
    chk("t4_issue_nodone", done_o, 4'b0000);
    tick();
    chk("t4_issue_ignored", done_o, 4'b0000);
    proc_ready_i = 4'b0000;
    tick();
    chk("t4_busy", done_o, 4'b0000);
    proc_ready_i = 4'b0001;
    tick();
    chk("t4_done2", done_o, 4'b0001);
    chk("t4_daddr2", daddr(0), 32'h440);
    proc_ready_i = 4'b0000;

    // config drain
    rst_pulse();
    push_one(32'h500);
    pkt_valid_i = 1'b1; pkt_addr_i = 32'h510;
    tick();
    chk("t5_s0", proc_start_o, 4'b0001);
    pkt_valid_i = 1'b0;
    cfg_req_i = 1'b1;
    tick();
    chk("t5_sameissue", proc_start_o, 4'b0011);
    chk("t5_gnt0", cfg_gnt_o, 0);
    push_one(32'h520);
    push_one(32'h530);
    push_one(32'h540);
    chk("t5_noissue", proc_start_o, 4'b0011);
    chk("t5_accept", pkt_ready_o, 1);
    chk("t5_gnt1", cfg_gnt_o, 0);
    proc_ready_i = 4'b0001;
    tick();
    chk("t5_done0", done_o, 4'b0001);
    proc_ready_i = 4'b0000;
    tick();
    chk("t5_noissue2", proc_start_o, 4'b0010);
    chk("t5_gnt2", cfg_gnt_o, 0);
    proc_ready_i = 4'b0010;
    tick();
    proc_ready_i = 4'b0000;
    tick();
    chk("t5_gnt3", cfg_gnt_o, 0);
    tick();
    chk("t5_gnt", cfg_gnt_o, 1);
    chk("t5_quiet", proc_start_o, 4'b0000);
    tick();
    chk("t5_gnthold", cfg_gnt_o, 1);
    chk("t5_busy", busy_o, 1);
    cfg_req_i = 1'b0;
    tick();
    chk("t5_gntdrop", cfg_gnt_o, 0);
    chk("t5_resume_wait", proc_start_o, 4'b0000);
    tick();
    chk("t5_resume", proc_start_o, 4'b0100);
    chk("t5_a2", paddr(2), 32'h520);
    tick(); tick();
    chk("t5_all", proc_start_o, 4'b1101);
    chk("t5_a0", paddr(0), 32'h540);

    // reset mid-operation
    for (int k = 0; k < 4; k++) push_one(32'h600 + 32'(k) * 32'h10);
    chk("t6_pre_start", proc_start_o, 4'b1111);
    chk("t6_pre_busy", busy_o, 1);
    chk("t6_a1", paddr(1), 32'h600);
    rst = 1'b1;
    tick();
    chk("t6_ready", pkt_ready_o, 1);
    chk("t6_start", proc_start_o, 0);
    chk("t6_paddr", proc_pkt_addr_o, 0);
    chk("t6_done", done_o, 0);
    chk("t6_daddr", done_addr_o, 0);
    chk("t6_gnt", cfg_gnt_o, 0);
    chk("t6_busy", busy_o, 0);
    rst = 1'b0;
    tick();
    chk("t6_empty_start", proc_start_o, 0);
    chk("t6_empty_busy", busy_o, 0);
    tick();
    chk("t6_empty_start2", proc_start_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_dispatcher.md
Name: pkt_dispatcher

Overview:
- Schedules packets across NUM_PROC parallel proc instances.
- Buffers incoming packet addresses in a FIFO and issues each to an idle proc using round-robin order.
- Drives each proc's start/ready handshake and reports completions.
- Quiesces all procs on a configuration request so the parser, matcher and proc modify buses can be driven safely. Modify is legal only while every proc is in its FREE state.

Parameters:
NUM_PROC, 4, number of proc instances served (2..8)
FIFO_DEPTH, 8, packet-address FIFO entries (power of 2, >=2)
ADDR_W, 32, packet address width (matches `ADDR_BUS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pkt_valid_i  in  1  packet address offered
pkt_addr_i  in  ADDR_W  packet base address
pkt_ready_o  out  1  FIFO can accept (registered, = !full)
proc_start_o  out  NUM_PROC  per-proc start_i drive
proc_pkt_addr_o  out  NUM_PROC*ADDR_W  per-proc pkt_addr_i, slot i at bits [i*ADDR_W +: ADDR_W]
proc_ready_i  in  NUM_PROC  per-proc ready_o
done_o  out  NUM_PROC  1-cycle pulse: slot i finished its packet
done_addr_o  out  NUM_PROC*ADDR_W  address of finished packet per slot; valid with done_o
cfg_req_i  in  1  level request for exclusive modify window
cfg_gnt_o  out  1  all procs quiescent; modify buses may be driven
busy_o  out  1  FIFO non-empty or any slot not IDLE

Behaviour:
- Reset (clk, rst synchronous active-high), including mid-operation reset:
  - Outputs: pkt_ready_o=1; proc_start_o=0; proc_pkt_addr_o=0; done_o=0; done_addr_o=0; cfg_gnt_o=0; busy_o=0.
  - Internal: FIFO emptied; all slots IDLE; rr pointer=0; top state RUN.
  - In-flight packets are lost; the procs reset alongside.
- FIFO:
  - Push when pkt_valid_i && pkt_ready_o.
  - Pop on issue.
  - Push and pop in the same cycle leaves the count unchanged.
  - No bypass: a packet pushed into an empty FIFO issues at the earliest on the next cycle.
  - pkt_ready_o is low when count==FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- Per-slot FSM:
  - IDLE -> ISSUE on issue: proc_start_o[i]<=1, proc_pkt_addr_o[i]<=FIFO head.
  - ISSUE lasts exactly 1 cycle, and proc_ready_i[i] is ignored during it. The proc's ready_o is still high from the prior packet until the proc samples start.
  - ISSUE -> BUSY unconditionally.
  - BUSY -> RELEASE when proc_ready_i[i]=1: proc_start_o[i]<=0; done_o[i]=1 and done_addr_o[i]=slot address for that one cycle.
  - RELEASE lasts 1 cycle with start low, so the proc leaves DONE. Then RELEASE -> IDLE.
  - proc_pkt_addr_o[i] holds its value until the next issue.
- Issue rule:
  - At most one issue per cycle.
  - Requires top state RUN, FIFO non-empty and at least one IDLE slot.
  - Slot chosen: first IDLE slot searching from rr pointer upward, wrapping at NUM_PROC.
  - After an issue, rr <= chosen+1 (mod NUM_PROC).
- Completions: multiple slots may complete in the same cycle; each gets its own done_o bit with no serialisation.
- Top FSM:
  - RUN: normal issue. cfg_req_i=1 -> DRAIN.
  - DRAIN: no new issues; FIFO keeps accepting pushes. Wait until all slots IDLE, then cfg_gnt_o<=1 -> CFG.
  - CFG: cfg_gnt_o held high and no issues. cfg_req_i=0 -> cfg_gnt_o<=0 -> RUN. Issuing may resume in the cycle after returning to RUN.
  - cfg_req_i dropped during DRAIN -> back to RUN without ever granting.
  - Request arriving on the same cycle as a would-be issue: that issue still occurs, because the request is sampled into the state first.
- busy_o: registered from the next-state values of FIFO count and the slot states.

Optional Feature:
- Macro: PKT_DISPATCHER_STATS_EN.
- Defined: adds outputs stat_issued_o[31:0] and stat_done_o[31:0].
  - stat_issued_o increments on each issue.
  - stat_done_o increments by popcount(done_o) each cycle.
  - Both counters are cleared by rst and wrap at 2^32.
  - Adds stat_max_occ_o[$clog2(FIFO_DEPTH):0], the high-water mark of the FIFO count.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single packet: push 0x100 with all procs idle. Expect:
  - proc_start_o=0001 two cycles after the push.
  - Proc model raises ready 5 cycles later -> done_o=0001 with done_addr_o[0]=0x100.
  - start falls; slot 0 becomes reusable after its RELEASE cycle.
- Round-robin: push 0x10,0x20,0x30,0x40,0x50 back-to-back with long proc latency. Expect:
  - Issues to slots 0,1,2,3 on consecutive cycles.
  - 0x50 waits until the first completion, then goes to the freed slot.
- FIFO full: stall all procs; push FIFO_DEPTH+NUM_PROC packets. Expect:
  - pkt_ready_o=0 once 8 are queued; the extra push is not accepted.
  - After one completion, pkt_ready_o returns to 1 the cycle after the pop.
- Stale ready: proc model keeps ready high after done. Expect reissue to the same slot with no spurious done_o during ISSUE.
- Config drain: with 2 procs BUSY and 3 packets queued, assert cfg_req_i. Expect:
  - No new issues.
  - cfg_gnt_o=1 only after both procs complete and release.
  - Deassert cfg_req_i -> gnt drops and the queued packets issue.
- Reset mid-operation: assert rst while slots are BUSY and the FIFO holds 3 entries. Expect all outputs at reset values next cycle and pkt_ready_o=1.
